// File: rtl/div_seq_if.sv
// Request/result bundle for the sequential divider.
// Master issues operands; slave returns quotient, remainder and flags.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] high;
  logic             busy;
  logic             div_end;
  logic             div_zero;
  logic             ovf;

  modport master (
    output start, signed_mode, a, b,
    input  low, high, busy, div_end,
    input  div_zero, ovf
  );

  modport slave (
    input  start, signed_mode, a, b,
    output low, high, busy, div_end,
    output div_zero, ovf
  );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per cycle.
// Quotient on low, remainder on high; flags zero divisor and MIN/-1.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  div_seq_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  state_e         state_q;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   quo_q;
  logic [W-1:0]   dvs_q;
  logic [W-1:0]   low_q;
  logic [W-1:0]   high_q;
  logic [CW-1:0]  cnt_q;
  logic           qneg_q;
  logic           rneg_q;
  logic           zero_q;
  logic           ovfp_q;
  logic           busy_q;
  logic           end_q;
  logic           dz_q;
  logic           ovf_q;

  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic           ovf_det;
  logic [W:0]     trial;
  logic [W-1:0]   q_fin;
  logic [W-1:0]   r_fin;

  always_comb begin
    a_neg   = bus.signed_mode & bus.a[W-1];
    b_neg   = bus.signed_mode & bus.b[W-1];
    a_mag   = a_neg ? ('0 - bus.a) : bus.a;
    b_mag   = b_neg ? ('0 - bus.b) : bus.b;
    ovf_det = bus.signed_mode
            & (bus.a == {1'b1, {(W-1){1'b0}}})
            & (bus.b == '1);
    // remainder < divisor, so the kept difference fits W bits
    trial   = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};
    q_fin   = qneg_q ? ('0 - quo_q) : quo_q;
    r_fin   = rneg_q ? ('0 - rem_q) : rem_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      low_q   <= '0;
      high_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovfp_q  <= 1'b0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          end_q <= 1'b0;
          if (bus.start) begin
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            ovfp_q <= ovf_det;
            dvs_q  <= b_mag;
            if (bus.b == '0) begin
              // raw dividend is parked in rem_q for the zero result
              zero_q  <= 1'b1;
              rem_q   <= bus.a;
              state_q <= FINISH;
            end else begin
              zero_q  <= 1'b0;
              rem_q   <= '0;
              quo_q   <= a_mag;
              cnt_q   <= CW'(W);
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (!trial[W]) rem_q <= trial[W-1:0];
          else           rem_q <= {rem_q[W-2:0], quo_q[W-1]};
          quo_q <= {quo_q[W-2:0], ~trial[W]};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= FINISH;
        end
        FINISH: begin
          busy_q  <= 1'b0;
          end_q   <= 1'b1;
          dz_q    <= zero_q;
          ovf_q   <= ovfp_q & ~zero_q;
          low_q   <= zero_q ? '1    : q_fin;
          high_q  <= zero_q ? rem_q : r_fin;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.low      = low_q;
  assign bus.high     = high_q;
  assign bus.busy     = busy_q;
  assign bus.div_end  = end_q;
  assign bus.div_zero = dz_q;
  assign bus.ovf      = ovf_q;
endmodule
